// File: rtl/antares_pipe_register_if.sv
// antares_pipe_register_if
// Valid/ready beat channel between two pipeline stages. The master drives
// data/ctrl/valid and the slave answers with ready.
//
// Handshake: a beat transfers on every rising clock edge where valid and
// ready are both high. The master keeps data/ctrl/valid stable while valid
// is high and ready is low. valid may depend on ready, but ready never
// depends combinationally on valid.
interface antares_pipe_register_if #(
    parameter int DATA_W = 70,
    parameter int CTRL_W = 2
);
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
    logic              ready;

    // Producer side of the channel.
    modport master (
        output data,
        output ctrl,
        output valid,
        input  ready
    );

    // Consumer side of the channel.
    modport slave (
        input  data,
        input  ctrl,
        input  valid,
        output ready
    );
endinterface

// File: rtl/antares_pipe_register.sv
// antares_pipe_register
// Generic pipeline stage register with valid/ready handshake. It has an
// optional one-entry skid buffer (SKID=1) that lets the upstream ready come
// straight from a flop. It also supports flush, clears the control fields of
// empty entries so bubbles never carry write enables, and keeps a saturating
// count of downstream stall cycles.
//
// Occupancy is kept as a (main_v, skid_v) state machine. The skid entry only
// fills under backpressure, so ordering is main first, then skid. With
// SKID=0 the machine never leaves EMPTY/FULL.
module antares_pipe_register #(
    parameter int DATA_W = 70,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    antares_pipe_register_if.slave  up,
    antares_pipe_register_if.master dn,
    input  logic                    flush,
    output logic [CNT_W-1:0]        stall_count,
    output logic [1:0]              o_dbg_state
);

    // State encoding is {main_v, skid_v}.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_FULL    = 2'b10,
        ST_SKIDDED = 2'b11
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_main_v;
    logic w_skid_v;
    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;
    logic w_stall;

    assign w_main_v = (r_state != ST_EMPTY);
    assign w_skid_v = (r_state == ST_SKIDDED);

    // Upstream ready: with a skid entry it comes from the skid flag alone.
    // Without one it looks through to the downstream ready. It is held low
    // during reset in both modes.
    always_comb begin
        if (SKID != 0) begin
            w_in_ready = !w_skid_v && !rst;
        end else begin
            w_in_ready = (dn.ready || !w_main_v) && !rst;
        end
    end

    assign w_in_fire  = up.valid && w_in_ready;
    assign w_out_fire = w_main_v && dn.ready;
    assign w_stall    = w_main_v && !dn.ready;

    assign up.ready    = w_in_ready;
    assign dn.data     = r_main_data;
    assign dn.ctrl     = r_main_ctrl;
    assign dn.valid    = w_main_v;
    assign stall_count = r_stall_cnt;
    assign o_dbg_state = r_state;

    // Occupancy FSM and entry registers. Reset beats flush, and flush beats
    // transfers. A flush drops every held beat plus any beat offered in the
    // same cycle. Clearing a valid flag also zeroes that entry's ctrl bits.
    // Data bits keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main_data <= up.data;
                        r_main_ctrl <= up.ctrl;
                        r_state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        // Pass-through: the new beat replaces the departing one.
                        r_main_data <= up.data;
                        r_main_ctrl <= up.ctrl;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new beat in skid. With
                        // SKID=0 in_ready blocks this case.
                        r_skid_data <= up.data;
                        r_skid_ctrl <= up.ctrl;
                        r_state     <= ST_SKIDDED;
                    end else if (w_out_fire) begin
                        r_main_ctrl <= '0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_SKIDDED: begin
                    if (w_out_fire) begin
                        // Older beat leaves; the skid beat moves up to main.
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                        r_skid_ctrl <= '0;
                        r_state     <= ST_FULL;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_main_ctrl <= '0;
                    r_skid_ctrl <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles with a beat waiting on a stalled downstream.
    // Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_antares_pipe_register.sv
// tb_antares_pipe_register
// Two instances run side by side: u_dut1 with SKID=1 and CNT_W=4, and
// u_dut0 with SKID=0 and CNT_W=16. The expected stream of each is a queue of
// accepted beats; flush and reset empty it.
module tb_antares_pipe_register;

    localparam int DW = 70;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    logic fl1, fl0;
    logic [3:0]  sc1;
    logic [15:0] sc0;
    logic [1:0]  st1, st0;
    logic        mon_en = 1'b0;

    antares_pipe_register_if #(.DATA_W(DW), .CTRL_W(CW)) up1();
    antares_pipe_register_if #(.DATA_W(DW), .CTRL_W(CW)) dn1();
    antares_pipe_register_if #(.DATA_W(DW), .CTRL_W(CW)) up0();
    antares_pipe_register_if #(.DATA_W(DW), .CTRL_W(CW)) dn0();

    antares_pipe_register #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .up(up1.slave), .dn(dn1.master),
        .flush(fl1), .stall_count(sc1), .o_dbg_state(st1)
    );

    antares_pipe_register #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .up(up0.slave), .dn(dn0.master),
        .flush(fl0), .stall_count(sc0), .o_dbg_state(st0)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Scoreboard state: expected beats {ctrl, data} and stall counts.
    logic [DW+CW-1:0] exp_q1[$];
    logic [DW+CW-1:0] exp_q0[$];
    int               exp_st1 = 0;
    int               exp_st0 = 0;
    logic [DW-1:0]    last_d0 = '0;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd70();
        return {6'($urandom()), $urandom(), $urandom()};
    endfunction

    // Issue side: a beat that is handed off (valid & ready) outside reset
    // and flush is pushed as expected output.
    always @(negedge clk) begin
        if (!rst && !fl1 && up1.valid && up1.ready) exp_q1.push_back({up1.ctrl, up1.data});
        if (!rst && !fl0 && up0.valid && up0.ready) begin
            exp_q0.push_back({up0.ctrl, up0.data});
            last_d0 = up0.data;
        end
        if (rst) last_d0 = '0;
    end

    // Monitor: at posedge+4 it compares outputs with the queue heads, then
    // pops on output transfers.
    always begin
        @(posedge clk);
        #4;
        if (mon_en) begin
            logic ev;
            logic [DW+CW-1:0] f;
            // SKID=1 instance
            ev = (exp_q1.size() != 0);
            chk("dut1_out_valid", 80'(dn1.valid), 80'(ev));
            chk("dut1_in_ready", 80'(up1.ready), 80'(!rst && exp_q1.size() < 2));
            chk("dut1_stall_count", 80'(sc1), 80'(exp_st1));
            if (ev) begin
                f = exp_q1[0];
                chk("dut1_out_data", 80'(dn1.data), 80'(f[DW-1:0]));
                chk("dut1_out_ctrl", 80'(dn1.ctrl), 80'(f[DW+CW-1:DW]));
            end else begin
                chk("dut1_bubble_ctrl", 80'(dn1.ctrl), 80'(0));
            end
            if (rst) begin
                exp_q1.delete();
                exp_st1 = 0;
            end else begin
                if (ev && !dn1.ready && exp_st1 < 15) exp_st1++;
                if (ev && dn1.ready) void'(exp_q1.pop_front());
                if (fl1) exp_q1.delete();
            end
            // SKID=0 instance
            ev = (exp_q0.size() != 0);
            chk("dut0_out_valid", 80'(dn0.valid), 80'(ev));
            chk("dut0_in_ready", 80'(up0.ready), 80'(!rst && (dn0.ready || !ev)));
            chk("dut0_stall_count", 80'(sc0), 80'(exp_st0));
            if (ev) begin
                f = exp_q0[0];
                chk("dut0_out_data", 80'(dn0.data), 80'(f[DW-1:0]));
                chk("dut0_out_ctrl", 80'(dn0.ctrl), 80'(f[DW+CW-1:DW]));
            end else begin
                chk("dut0_bubble_ctrl", 80'(dn0.ctrl), 80'(0));
                chk("dut0_bubble_data", 80'(dn0.data), 80'(last_d0));
            end
            if (rst) begin
                exp_q0.delete();
                exp_st0 = 0;
            end else begin
                if (ev && !dn0.ready && exp_st0 < 65535) exp_st0++;
                if (ev && dn0.ready) void'(exp_q0.pop_front());
                if (fl0) exp_q0.delete();
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #2;
    endtask

    task automatic set1(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic f);
        up1.valid = v; up1.data = d; up1.ctrl = c; dn1.ready = ordy; fl1 = f;
    endtask

    task automatic set0(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic f);
        up0.valid = v; up0.data = d; up0.ctrl = c; dn0.ready = ordy; fl0 = f;
    endtask

    initial begin
        rst = 1'b1;
        set1(1'b0, '0, '0, 1'b1, 1'b0);
        set0(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        mon_en = 1'b1;
        // Reset state, still inside reset.
        peek();
        chk("rst_out_valid", 80'(dn1.valid), 80'(0));
        chk("rst_out_data", 80'(dn1.data), 80'(0));
        chk("rst_out_ctrl", 80'(dn1.ctrl), 80'(0));
        chk("rst_stall_count", 80'(sc1), 80'(0));
        chk("rst_in_ready1", 80'(up1.ready), 80'(0));
        chk("rst_in_ready0", 80'(up0.ready), 80'(0));
        tick();
        rst = 1'b0;
        peek();
        chk("post_rst_in_ready1", 80'(up1.ready), 80'(1));
        chk("post_rst_in_ready0", 80'(up0.ready), 80'(1));

        // Streaming D=1..8 into both instances.
        tick();
        for (int i = 1; i <= 8; i++) begin
            set1(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
            set0(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
            tick();
        end
        set1(1'b0, '0, '0, 1'b1, 1'b0);
        set0(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        tick();
        chk("stream_stall_count", 80'(sc1), 80'(0));

        // Backpressure: A then B, out_ready low for 3 cycles.
        set1(1'b1, DW'('hA), 2'b01, 1'b1, 1'b0);
        tick();
        set1(1'b1, DW'('hB), 2'b10, 1'b0, 1'b0);
        tick();
        set1(1'b0, '0, '0, 1'b0, 1'b0);
        peek();
        chk("bp_in_ready_low", 80'(up1.ready), 80'(0));
        chk("bp_hold_a", 80'(dn1.data), 80'('hA));
        tick();
        tick();
        set1(1'b0, '0, '0, 1'b1, 1'b0);
        peek();
        chk("bp_out_a", 80'(dn1.data), 80'('hA));
        tick();
        peek();
        chk("bp_out_b", 80'(dn1.data), 80'('hB));
        chk("bp_in_ready_back", 80'(up1.ready), 80'(1));
        tick();
        peek();
        chk("bp_stall_count", 80'(sc1), 80'(3));

        // Flush while SKIDDED with ctrl=11 in both entries; 0xC offered in the flush cycle.
        tick();
        set1(1'b1, DW'('hC1), 2'b11, 1'b1, 1'b0);
        tick();
        set1(1'b1, DW'('hC2), 2'b11, 1'b0, 1'b0);
        tick();
        set1(1'b1, DW'('hC), 2'b11, 1'b0, 1'b1);
        peek();
        chk("flush_state_skidded", 80'(st1), 80'(2'b11));
        tick();
        set1(1'b0, '0, '0, 1'b1, 1'b0);
        peek();
        chk("flush_out_valid", 80'(dn1.valid), 80'(0));
        chk("flush_out_ctrl", 80'(dn1.ctrl), 80'(0));
        chk("flush_in_ready", 80'(up1.ready), 80'(1));
        tick();

        // Saturation: one beat held for 20 stalled cycles.
        set1(1'b1, DW'('h77), 2'b01, 1'b0, 1'b0);
        tick();
        set1(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (20) tick();
        peek();
        chk("sat_stall_count", 80'(sc1), 80'(15));
        tick();
        peek();
        chk("sat_stall_hold", 80'(sc1), 80'(15));
        set1(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        tick();

        // Bubble on the SKID=0 instance.
        set0(1'b1, DW'('h5A), 2'b01, 1'b1, 1'b0);
        tick();
        set0(1'b0, '0, '0, 1'b1, 1'b0);
        peek();
        chk("bubble_ctrl_live", 80'(dn0.ctrl), 80'(2'b01));
        tick();
        peek();
        chk("bubble_valid_low", 80'(dn0.valid), 80'(0));
        chk("bubble_ctrl_zero", 80'(dn0.ctrl), 80'(0));
        chk("bubble_data_kept", 80'(dn0.data), 80'('h5A));
        tick();

        // Reset while SKIDDED.
        set1(1'b1, DW'('hD1), 2'b10, 1'b1, 1'b0);
        tick();
        set1(1'b1, DW'('hD2), 2'b10, 1'b0, 1'b0);
        tick();
        set1(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        set1(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        peek();
        chk("mid_rst_valid", 80'(dn1.valid), 80'(0));
        chk("mid_rst_data", 80'(dn1.data), 80'(0));
        chk("mid_rst_ctrl", 80'(dn1.ctrl), 80'(0));
        chk("mid_rst_in_ready", 80'(up1.ready), 80'(0));
        chk("mid_rst_stall", 80'(sc1), 80'(0));
        tick();
        rst = 1'b0;
        set1(1'b1, DW'('hE), 2'b01, 1'b1, 1'b0);
        peek();
        chk("after_rst_in_ready", 80'(up1.ready), 80'(1));
        tick();
        set1(1'b0, '0, '0, 1'b1, 1'b0);
        peek();
        chk("after_rst_latency1", 80'(dn1.valid), 80'(1));
        chk("after_rst_data", 80'(dn1.data), 80'('hE));
        tick();

        // Random traffic with occasional flush on both instances.
        for (int i = 0; i < 400; i++) begin
            set1(1'($urandom_range(0, 1)), rnd70(), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
            set0(1'($urandom_range(0, 1)), rnd70(), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
            tick();
        end
        set1(1'b0, '0, '0, 1'b1, 1'b0);
        set0(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (5) tick();
        chk("drain_q1_empty", 80'(exp_q1.size()), 80'(0));
        chk("drain_q0_empty", 80'(exp_q0.size()), 80'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
